// File: rtl/dot_sqrt.sv
// Bit-serial restoring square root: pops one signed Q-format sample, produces
// floor(sqrt(x)) in the same Q format (one root bit per cycle), pushes the result.
module dot_sqrt #(
    parameter int Q_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_dout,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic [31:0] out_din,
    input  logic        out_full,
    output logic        out_wr_en
);

    localparam int RAD_W = 32 + Q_BITS + ((32 + Q_BITS) % 2);
    localparam int ITER  = RAD_W / 2;
    localparam int REM_W = ITER + 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [RAD_W-1:0] rad_reg;
    logic [REM_W-1:0] rem_reg;
    logic [ITER-1:0]  root_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             sample_pos;
    logic             calc_done;
    logic             trial_fits;
    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] trial;
    logic [REM_W-1:0] rem_calc;
    logic [ITER-1:0]  root_calc;

    // One restoring step. The remainder never exceeds 2*root, so its two top
    // bits are always zero before the shift and nothing is lost.
    always_comb begin
        sample_pos = !in_dout[31] && (|in_dout[30:0]);
        calc_done  = (cnt_reg == '0);
        rem_shift  = {rem_reg[REM_W-3:0], rad_reg[RAD_W-1 -: 2]};
        trial      = {root_reg, 2'b01};
        trial_fits = (rem_shift >= trial);
        rem_calc   = trial_fits ? (rem_shift - trial) : rem_shift;
        root_calc  = {root_reg[ITER-2:0], trial_fits};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!in_empty) begin
                    state_next = sample_pos ? CALC : WRITE;
                end
            end
            CALC: begin
                if (calc_done) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are held low while reset is asserted, even if a sample is waiting.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        if (reset) begin
            in_rd_en  = (state_reg == IDLE) && !in_empty;
            out_wr_en = (state_reg == WRITE) && !out_full;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rad_reg  <= '0;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= '0;
            out_din  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_rd_en) begin
                        rem_reg  <= '0;
                        root_reg <= '0;
                        if (sample_pos) begin
                            rad_reg <= RAD_W'({in_dout, {Q_BITS{1'b0}}});
                            cnt_reg <= CNT_LAST;
                        end else begin
                            rad_reg <= '0;
                            out_din <= '0;
                        end
                    end
                end
                CALC: begin
                    rad_reg  <= rad_reg << 2;
                    rem_reg  <= rem_calc;
                    root_reg <= root_calc;
                    if (calc_done) begin
                        out_din <= 32'(root_calc);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_sqrt.sv
// Directed bench for dot_sqrt: FIFO-like source/sink around the DUT, inline checks per scenario.
module tb_dot_sqrt;

    localparam int Q_BITS = 10;

    logic        clock;
    logic        reset;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] out_din;
    logic        out_full;
    logic        out_wr_en;

    dot_sqrt #(.Q_BITS(Q_BITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_din   (out_din),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_pops = 0;
    int          n_wrs = 0;
    int          last_pop_cyc = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] src[$];
    logic [31:0] got[$];
    logic        saw_rd;
    logic        saw_wr;
    logic [31:0] seen_din;

    function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
        longint unsigned x;
        longint unsigned r;
        longint unsigned t;
        if (v[31] || v == 32'd0) return 32'd0;
        x = longint'(v) << Q_BITS;
        r = 0;
        for (int b = 22; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return 32'(r);
    endfunction

    task automatic drive_src();
        in_empty = (src.size() == 0);
        in_dout  = in_empty ? 32'd0 : src[0];
    endtask

    // Sample DUT strobes mid-cycle, then apply the FIFO effects of the edge.
    task automatic tick();
        @(negedge clock);
        saw_rd   = in_rd_en;
        saw_wr   = out_wr_en;
        seen_din = out_din;
        @(posedge clock);
        #1;
        cyc++;
        if (saw_rd) begin
            n_pops++;
            last_pop_cyc = cyc;
            if (src.size() > 0) void'(src.pop_front());
        end
        if (saw_wr) begin
            n_wrs++;
            last_wr_cyc  = cyc;
            last_wr_data = seen_din;
            got.push_back(seen_din);
        end
        drive_src();
    endtask

    task automatic run_one(input logic [31:0] v, output logic [31:0] res, output int lat, output bit ok);
        int w0;
        int k;
        w0 = n_wrs;
        k  = 0;
        src.push_back(v);
        drive_src();
        while (n_wrs == w0 && k < 80) begin
            tick();
            k++;
        end
        ok  = (n_wrs != w0);
        res = last_wr_data;
        lat = last_wr_cyc - last_pop_cyc;
        $display("sample in=0x%08h out=%0d latency=%0d", v, res, lat);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        out_full = 1'b0;
        drive_src();
        repeat (3) tick();
        n_cmp++; if (out_din !== 32'd0) begin n_err++; $display("FAIL reset_out_din got %0d want 0", out_din); end
        n_cmp++; if (out_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", out_wr_en); end
        src.push_back(32'd100);
        drive_src();
        #1;
        n_cmp++; if (in_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", in_rd_en); end
        tick();
        n_cmp++; if (n_pops !== 0) begin n_err++; $display("FAIL reset_no_pop got %0d want 0", n_pops); end
        src.delete();
        drive_src();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat;
        bit ok;
        int p0;
        int w0;
        p0 = n_pops;
        w0 = n_wrs;
        run_one(32'd4096, res, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic4_timeout got %b want 1", ok); end
        n_cmp++; if (res !== 32'd2048) begin n_err++; $display("FAIL basic4_value got %0d want 2048", res); end
        n_cmp++; if (lat !== 22) begin n_err++; $display("FAIL basic4_latency got %0d want 22", lat); end
        n_cmp++; if (n_pops - p0 !== 1) begin n_err++; $display("FAIL basic4_pops got %0d want 1", n_pops - p0); end
        n_cmp++; if (n_wrs - w0 !== 1) begin n_err++; $display("FAIL basic4_writes got %0d want 1", n_wrs - w0); end
        run_one(32'd2048, res, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic2_timeout got %b want 1", ok); end
        n_cmp++; if (res !== 32'd1448) begin n_err++; $display("FAIL basic2_value got %0d want 1448", res); end
    endtask

    task automatic test_nonpositive();
        int c0;
        int w0;
        int p0;
        int k;
        int pop_c[2];
        int wr_c[2];
        c0 = cyc;
        w0 = n_wrs;
        p0 = n_pops;
        k  = 0;
        got.delete();
        src.push_back(32'hFFFF_FC00);
        src.push_back(32'd0);
        drive_src();
        while (n_wrs < w0 + 2 && k < 12) begin
            tick();
            k++;
            if (saw_rd && n_pops - p0 <= 2) pop_c[n_pops - p0 - 1] = cyc;
            if (saw_wr && n_wrs - w0 <= 2) wr_c[n_wrs - w0 - 1] = cyc;
        end
        n_cmp++; if (n_wrs - w0 !== 2) begin n_err++; $display("FAIL nonpos_writes got %0d want 2", n_wrs - w0); end
        if (n_wrs - w0 == 2) begin
            for (int i = 0; i < 2; i++) begin
                $display("sample in=%s out=%0d", (i == 0) ? "-1.0" : "0", got[i]);
                n_cmp++; if (got[i] !== 32'd0) begin n_err++; $display("FAIL nonpos_value%0d got %0d want 0", i, got[i]); end
                n_cmp++; if (pop_c[i] !== c0 + 1 + 2 * i) begin n_err++; $display("FAIL nonpos_pop_cycle%0d got %0d want %0d", i, pop_c[i] - c0, 1 + 2 * i); end
                n_cmp++; if (wr_c[i] !== c0 + 2 + 2 * i) begin n_err++; $display("FAIL nonpos_wr_cycle%0d got %0d want %0d", i, wr_c[i] - c0, 2 + 2 * i); end
            end
        end
    endtask

    task automatic test_max();
        logic [31:0] res;
        int lat;
        bit ok;
        run_one(32'h7FFF_FFFF, res, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL max_timeout got %b want 1", ok); end
        n_cmp++; if (res !== 32'd1482910) begin n_err++; $display("FAIL max_value got %0d want 1482910", res); end
        n_cmp++; if (lat !== 22) begin n_err++; $display("FAIL max_latency got %0d want 22", lat); end
    endtask

    task automatic test_backpressure();
        int p0;
        int w0;
        int k;
        out_full = 1'b1;
        p0 = n_pops;
        w0 = n_wrs;
        k  = 0;
        src.push_back(32'd4096);
        drive_src();
        while (n_pops == p0 && k < 5) begin tick(); k++; end
        repeat (21) tick();
        src.push_back(32'd9216);
        drive_src();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (saw_wr !== 1'b0) begin n_err++; $display("FAIL full_wr_en%0d got %b want 0", i, saw_wr); end
            n_cmp++; if (saw_rd !== 1'b0) begin n_err++; $display("FAIL full_rd_en%0d got %b want 0", i, saw_rd); end
            n_cmp++; if (seen_din !== 32'd2048) begin n_err++; $display("FAIL full_out_din%0d got %0d want 2048", i, seen_din); end
        end
        out_full = 1'b0;
        tick();
        $display("sample in=4096 out=%0d after backpressure", seen_din);
        n_cmp++; if (saw_wr !== 1'b1) begin n_err++; $display("FAIL full_release_wr got %b want 1", saw_wr); end
        n_cmp++; if (seen_din !== 32'd2048) begin n_err++; $display("FAIL full_release_value got %0d want 2048", seen_din); end
        k = 0;
        while (n_wrs < w0 + 2 && k < 40) begin tick(); k++; end
        $display("sample in=9216 out=%0d", last_wr_data);
        n_cmp++; if (n_wrs - w0 !== 2) begin n_err++; $display("FAIL full_second_writes got %0d want 2", n_wrs - w0); end
        n_cmp++; if (last_wr_data !== 32'd3072) begin n_err++; $display("FAIL full_second_value got %0d want 3072", last_wr_data); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int lat;
        bit ok;
        int p0;
        int w0;
        int k;
        p0 = n_pops;
        k  = 0;
        src.push_back(32'd4096);
        drive_src();
        while (n_pops == p0 && k < 5) begin tick(); k++; end
        repeat (4) tick();
        w0 = n_wrs;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_din !== 32'd0) begin n_err++; $display("FAIL midreset_out_din got %0d want 0", out_din); end
        n_cmp++; if (out_wr_en !== 1'b0) begin n_err++; $display("FAIL midreset_wr_en got %b want 0", out_wr_en); end
        repeat (3) tick();
        reset = 1'b1;
        repeat (30) tick();
        n_cmp++; if (n_wrs !== w0) begin n_err++; $display("FAIL midreset_no_write got %0d want %0d", n_wrs, w0); end
        n_cmp++; if (out_din !== 32'd0) begin n_err++; $display("FAIL midreset_idle_out got %0d want 0", out_din); end
        run_one(32'd9216, res, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL midreset_fresh_timeout got %b want 1", ok); end
        n_cmp++; if (res !== 32'd3072) begin n_err++; $display("FAIL midreset_fresh_value got %0d want 3072", res); end
        n_cmp++; if (lat !== 22) begin n_err++; $display("FAIL midreset_fresh_latency got %0d want 22", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[$];
        int c0;
        int p0;
        int w0;
        int k;
        logic [31:0] v;
        logic [31:0] want;
        got.delete();
        for (int i = 0; i < 100; i++) begin
            v = ($urandom() & 32'h7FFF_FFFF) | 32'd1;
            if (i % 4 == 0) v = v >> $urandom_range(30, 1);
            if (v == 32'd0) v = 32'd1;
            vals.push_back(v);
            src.push_back(v);
        end
        c0 = cyc;
        p0 = n_pops;
        w0 = n_wrs;
        k  = 0;
        drive_src();
        while (n_wrs < w0 + 100 && k < 2500) begin tick(); k++; end
        n_cmp++; if (n_wrs - w0 !== 100) begin n_err++; $display("FAIL b2b_writes got %0d want 100", n_wrs - w0); end
        n_cmp++; if (n_pops - p0 !== 100) begin n_err++; $display("FAIL b2b_pops got %0d want 100", n_pops - p0); end
        n_cmp++; if (last_wr_cyc - c0 !== 2300) begin n_err++; $display("FAIL b2b_total_cycles got %0d want 2300", last_wr_cyc - c0); end
        for (int i = 0; i < 100 && i < got.size(); i++) begin
            want = ref_sqrt(vals[i]);
            $display("sample %0d in=0x%08h out=%0d", i, vals[i], got[i]);
            n_cmp++; if (got[i] !== want) begin n_err++; $display("FAIL b2b_value%0d in=0x%08h got %0d want %0d", i, vals[i], got[i], want); end
        end
    endtask

    initial begin
        reset    = 1'b0;
        out_full = 1'b0;
        in_empty = 1'b1;
        in_dout  = 32'd0;
        test_reset();
        test_basic();
        test_nonpositive();
        test_max();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
